inst_prefetch: RTL and testbench
================================

Name: inst_prefetch

Overview:
- Instruction prefetch unit directly upstream of the fetch stage.
- Issues word-aligned 32-bit reads to instruction memory and splits each returned word into Thumb halfwords, low halfword first.
- Buffers the halfwords in a small FIFO with a PC sideband and presents one halfword per cycle on a valid/ready interface that drives the core's inst_hw input.
- Flushes and redirects on a branch request from the core.

Parameters:
- DEPTH, 4, halfword FIFO entries; power of two, minimum 2.
- RESET_PC, 32'h0000_0000, fetch address after reset; halfword aligned.

Ports:
- clk  input  1  core clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- imem_req  output  1  one-cycle request pulse; memory always accepts.
- imem_addr  output  32  word address of the request; bits[1:0] = 0; valid when imem_req = 1.
- imem_rvalid  input  1  response strobe; exactly one per request, arriving at least 1 cycle after the request.
- imem_rdata  input  32  response word, little-endian.
- br_valid  input  1  redirect strobe from the core.
- br_target  input  32  redirect address; bit0 ignored.
- hw_valid  output  1  FIFO head valid.
- hw_data  output  16  halfword at the FIFO head (drives inst_hw).
- hw_pc  output  32  address of hw_data.
- hw_ready  input  1  consumer accepts the head this cycle.

Behaviour:
- Reset (rst = 0, asynchronous):
  - FIFO empty, so hw_valid = 0, hw_data = 0, hw_pc = 0.
  - imem_req = 0, imem_addr = 0.
  - fetch_pc = RESET_PC; state = IDLE.
- Registers: fetch_pc[31:1] holds the next halfword to fetch. imem_addr = {fetch_pc[31:2], 2'b00}.
- IDLE state:
  - If count <= DEPTH-2 and br_valid = 0, pulse imem_req and go to WAIT.
  - The first request comes in the first clock edge after rst deasserts.
- WAIT state, on imem_rvalid:
  - If fetch_pc[1] = 0, push rdata[15:0] at fetch_pc, then rdata[31:16] at fetch_pc+2.
  - If fetch_pc[1] = 1, push rdata[31:16] only.
  - Advance fetch_pc to the next word base (+4 or +2).
  - Go to IDLE. The next request may issue the following cycle.
- At most one request is outstanding. The space check is made at request time, so no overflow is possible because pops only free space.
- Pop: when hw_valid && hw_ready, the head advances. Push and pop in the same cycle are both honoured; count changes by pushes minus pops.
- Latency: with a 1-cycle memory, imem_req at cycle N, rvalid at N+1, hw_valid = 1 at N+2.
- Branch, any state (br_valid = 1):
  - FIFO flushed that cycle, overriding any simultaneous pop or push.
  - fetch_pc = {br_target[31:1], 1'b0}.
  - No request is issued in that cycle.
- Branch while in WAIT, or together with rvalid in WAIT:
  - If rvalid was not in the same cycle, go to DISCARD.
  - If rvalid arrived in the same cycle, that response is dropped and the state goes to IDLE.
- DISCARD state:
  - The next rvalid is dropped, and the state goes to IDLE.
  - A further br_valid in DISCARD updates fetch_pc and stays in DISCARD.
- Pointers wrap modulo DEPTH. Full is count == DEPTH; empty is count == 0.
- hw_data and hw_pc hold while hw_valid && !hw_ready.
- Reset asserted mid-WAIT: the state returns to IDLE and any later rvalid from the old request is ignored. The memory model is also reset.

Decomposition:
- Package arm_if_pkg:
  - Fetch state enum {IDLE, WAIT, DISCARD}.
  - HW_W = 16, ADDR_W = 32.
- Sub-module hw_fifo:
  - DEPTH-entry {pc, halfword} FIFO.
  - 0–2 pushes and 0–1 pop per cycle, synchronous flush, count output.
- inst_prefetch holds the FSM, fetch_pc and the push-select logic.

Test Plan:
- Reset with RESET_PC = 0, 1-cycle memory returning 0x2001_1000 and 0x2003_1002, hw_ready = 1:
  - imem_addr 0 then 4.
  - Halfwords 0x1000@0, 0x2001@2, 0x1002@4, 0x2003@6 in order.
  - First hw_valid two cycles after the first imem_req.
- br_valid with br_target = 0x0000_0102, memory word at 0x100 = 0xBBBB_AAAA:
  - Request to 0x100.
  - Only 0xBBBB@0x102 is pushed; next request to 0x104.
- br_valid during WAIT to 0x200, with a 3-cycle memory latency:
  - The stale response is dropped and no hw_valid results from it.
  - Next imem_addr = 0x200.
- hw_ready = 0 for 10 cycles:
  - count saturates at DEPTH and no imem_req is issued while count > DEPTH-2.
  - Head is stable, with no loss or duplication after hw_ready = 1.
- br_valid in the same cycle as imem_rvalid and hw_ready:
  - FIFO empty next cycle and the response is not pushed.
  - State IDLE, with a request to the target on the following cycle.
- rst low in WAIT, then released:
  - All outputs return to reset values.
  - First imem_addr = RESET_PC.

Source files
------------

// File: rtl/arm_if_pkg.sv
// Shared types and widths for the instruction-fetch front end.
// Used by the prefetch controller and its halfword FIFO.
package arm_if_pkg;

  localparam int HW_W   = 16;
  localparam int ADDR_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DISCARD
  } fetch_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [HW_W-1:0]   hw;
  } hw_entry_t;

endpackage

// File: rtl/hw_fifo.sv
// DEPTH-entry {pc, halfword} FIFO.
// Accepts up to two pushes and one pop per cycle, and a synchronous flush that overrides both.
module hw_fifo
  import arm_if_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic [1:0]        push_n,
  input  logic [ADDR_W-1:0] push_pc0,
  input  logic [HW_W-1:0]   push_hw0,
  input  logic [ADDR_W-1:0] push_pc1,
  input  logic [HW_W-1:0]   push_hw1,
  input  logic              pop,
  output logic              head_valid,
  output logic [HW_W-1:0]   head_hw,
  output logic [ADDR_W-1:0] head_pc,
  output logic [CNT_W-1:0]  count
);

  hw_entry_t        mem_q [DEPTH];
  hw_entry_t        mem_d [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_pop;

  always_comb begin
    // NOTE: every signal gets a default first so no path through the block infers a latch.
    do_pop   = pop && (count_q != '0);
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_n != 2'd0) begin
        mem_d[wr_ptr_q].pc = push_pc0;
        mem_d[wr_ptr_q].hw = push_hw0;
      end
      if (push_n == 2'd2) begin
        mem_d[wr_ptr_q + PTR_W'(1)].pc = push_pc1;
        mem_d[wr_ptr_q + PTR_W'(1)].hw = push_hw1;
      end
      wr_ptr_d = wr_ptr_q + PTR_W'(push_n);
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push_n) - CNT_W'(do_pop);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; the head outputs are forced to zero while empty instead.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head_valid = (count_q != '0);
  assign head_hw    = head_valid ? mem_q[rd_ptr_q].hw : '0;
  assign head_pc    = head_valid ? mem_q[rd_ptr_q].pc : '0;
  assign count      = count_q;

endmodule

// File: rtl/inst_prefetch.sv
// Instruction prefetch unit: word fetches from imem, split into Thumb halfwords,
// buffered with their PCs and presented one per cycle to the fetch stage.
module inst_prefetch
  import arm_if_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        br_valid,
  input  logic [31:0] br_target,
  output logic        hw_valid,
  output logic [15:0] hw_data,
  output logic [31:0] hw_pc,
  input  logic        hw_ready
);

  localparam int               CNT_W   = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] REQ_MAX = CNT_W'(DEPTH - 2);

  fetch_state_e state_q, state_d;
  logic [31:1]  fetch_pc_q, fetch_pc_d;
  logic         imem_req_q, imem_req_d;
  logic [31:0]  imem_addr_q, imem_addr_d;

  logic [1:0]       push_n;
  logic [31:0]      push_pc0, push_pc1;
  logic [15:0]      push_hw0, push_hw1;
  logic [CNT_W-1:0] count;
  logic [31:1]      next_word_pc;
  logic             unused_br_bit0;

  assign next_word_pc   = {fetch_pc_q[31:2] + 30'd1, 1'b0};
  assign unused_br_bit0 = br_target[0];

  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    imem_req_d  = 1'b0;
    imem_addr_d = imem_addr_q;
    push_n      = 2'd0;
    push_pc0    = {fetch_pc_q, 1'b0};
    push_hw0    = imem_rdata[15:0];
    push_pc1    = {fetch_pc_q[31:2], 2'b10};
    push_hw1    = imem_rdata[31:16];

    // A branch always wins: retarget, never request or push in the same cycle.
    if (br_valid) begin
      fetch_pc_d = br_target[31:1];
    end

    case (state_q)
      IDLE: begin
        if (!br_valid && (count <= REQ_MAX)) begin
          imem_req_d  = 1'b1;
          imem_addr_d = {fetch_pc_q[31:2], 2'b00};
          state_d     = WAIT;
        end
      end
      WAIT: begin
        if (br_valid) begin
          state_d = imem_rvalid ? IDLE : DISCARD;
        end else if (imem_rvalid) begin
          if (fetch_pc_q[1]) begin
            push_n   = 2'd1;
            push_hw0 = imem_rdata[31:16];
          end else begin
            push_n = 2'd2;
          end
          fetch_pc_d = next_word_pc;
          state_d    = IDLE;
        end
      end
      DISCARD: begin
        if (imem_rvalid) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      fetch_pc_q  <= RESET_PC[31:1];
      imem_req_q  <= 1'b0;
      imem_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      imem_req_q  <= imem_req_d;
      imem_addr_q <= imem_addr_d;
    end
  end

  assign imem_req  = imem_req_q;
  assign imem_addr = imem_addr_q;

  hw_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst),
    .flush      (br_valid),
    .push_n     (push_n),
    .push_pc0   (push_pc0),
    .push_hw0   (push_hw0),
    .push_pc1   (push_pc1),
    .push_hw1   (push_hw1),
    .pop        (hw_ready),
    .head_valid (hw_valid),
    .head_hw    (hw_data),
    .head_pc    (hw_pc),
    .count      (count)
  );

endmodule

// File: tb/tb_inst_prefetch.sv
// Directed and randomized bench for inst_prefetch against a program-order halfword stream model.
module tb_inst_prefetch;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        br_valid;
  logic [31:0] br_target;
  logic        hw_valid;
  logic [15:0] hw_data;
  logic [31:0] hw_pc;
  logic        hw_ready;

  always #5 clk = ~clk;

  inst_prefetch #(
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .br_valid    (br_valid),
    .br_target   (br_target),
    .hw_valid    (hw_valid),
    .hw_data     (hw_data),
    .hw_pc       (hw_pc),
    .hw_ready    (hw_ready)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;
  int          lat      = 1;
  int          pops     = 0;
  int          first_req_cyc;
  int          first_valid_cyc;
  mreq_t       pend[$];
  logic [31:0] req_log[$];
  logic [31:0] pop_pc_log[$];
  logic [15:0] pop_hw_log[$];
  logic [31:0] exp_pc;
  logic        last_req, last_valid;
  logic [31:0] last_addr, last_pc;
  logic [15:0] last_hw;
  logic        found;

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    case (addr)
      32'h0000_0000: return 32'h2001_1000;
      32'h0000_0004: return 32'h2003_1002;
      32'h0000_0100: return 32'hBBBB_AAAA;
      default:       return {addr[15:0] ^ 16'hC35A, addr[15:0] + 16'h0111};
    endcase
  endfunction

  function automatic logic [15:0] mem_hw(input logic [31:0] pc);
    logic [31:0] w;
    w = mem_word({pc[31:2], 2'b00});
    return pc[1] ? w[31:16] : w[15:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    req_log.delete();
    pop_pc_log.delete();
    pop_hw_log.delete();
    first_req_cyc   = -1;
    first_valid_cyc = -1;
  endtask

  // One clock cycle, entered just after a falling edge: drive inputs, model memory, score outputs.
  task automatic cycle(input logic rdy, input logic br, input logic [31:0] tgt);
    hw_ready  = rdy;
    br_valid  = br;
    br_target = tgt;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(pend[0].addr);
      void'(pend.pop_front());
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
    #1;
    last_req   = imem_req;
    last_addr  = imem_addr;
    last_valid = hw_valid;
    last_pc    = hw_pc;
    last_hw    = hw_data;
    if (imem_req) begin
      check("req_align", {30'd0, imem_addr[1:0]}, 32'd0);
      check("one_outstanding", pend.size(), 32'd0);
      pend.push_back('{addr: imem_addr, due: cyc + lat});
      req_log.push_back(imem_addr);
      if (first_req_cyc < 0) first_req_cyc = cyc;
    end
    if (hw_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (br) begin
      exp_pc = {tgt[31:1], 1'b0};
    end else if (hw_valid && rdy) begin
      check("stream_pc", hw_pc, exp_pc);
      check("stream_hw", {16'd0, hw_data}, {16'd0, mem_hw(exp_pc)});
      pop_pc_log.push_back(hw_pc);
      pop_hw_log.push_back(hw_data);
      exp_pc = exp_pc + 32'd2;
      pops++;
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"},   {31'd0, imem_req}, 32'd0);
    check({tag, "_addr"},  imem_addr, 32'd0);
    check({tag, "_valid"}, {31'd0, hw_valid}, 32'd0);
    check({tag, "_data"},  {16'd0, hw_data}, 32'd0);
    check({tag, "_pc"},    hw_pc, 32'd0);
  endtask

  initial begin
    rst         = 1'b1;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    br_valid    = 1'b0;
    br_target   = '0;
    hw_ready    = 1'b0;
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);

    // Power-up stream from RESET_PC with a 1-cycle memory
    rst    = 1'b1;
    exp_pc = RESET_PC;
    lat    = 1;
    clear_logs();
    repeat (12) cycle(1'b1, 1'b0, '0);
    check("t1_req0", req_log[0], 32'h0);
    check("t1_req1", req_log[1], 32'h4);
    check("t1_latency", first_valid_cyc - first_req_cyc, 32'd2);
    check("t1_hw0", {pop_pc_log[0], pop_hw_log[0]} >> 16 == RESET_PC ? {16'd0, pop_hw_log[0]} : 32'hDEAD, 32'h1000);
    check("t1_hw1", {16'd0, pop_hw_log[1]}, 32'h2001);
    check("t1_hw2", {16'd0, pop_hw_log[2]}, 32'h1002);
    check("t1_hw3", {16'd0, pop_hw_log[3]}, 32'h2003);
    check("t1_pc3", pop_pc_log[3], 32'h6);

    // Branch to an odd halfword: only the upper half of the first word is used
    cycle(1'b1, 1'b1, 32'h0000_0102);
    clear_logs();
    repeat (12) cycle(1'b1, 1'b0, '0);
    check("t2_req0", req_log[0], 32'h100);
    check("t2_req1", req_log[1], 32'h104);
    check("t2_pc0", pop_pc_log[0], 32'h102);
    check("t2_hw0", {16'd0, pop_hw_log[0]}, 32'h0000_BBBB);
    check("t2_pc1", pop_pc_log[1], 32'h104);

    // Branch while a slow (3-cycle) response is outstanding
    lat = 3;
    cycle(1'b1, 1'b1, 32'h0000_0300);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      cycle(1'b1, 1'b0, '0);
      found = last_req && (last_addr == 32'h300);
    end
    check("t3_req_seen", {31'd0, found}, 32'd1);
    cycle(1'b1, 1'b1, 32'h0000_0200);
    clear_logs();
    repeat (20) cycle(1'b1, 1'b0, '0);
    check("t3_req0", req_log[0], 32'h200);
    check("t3_pc0", pop_pc_log[0], 32'h200);

    // Consumer stall: FIFO fills, requests stop, head holds
    lat = 1;
    cycle(1'b0, 1'b1, 32'h0000_0400);
    clear_logs();
    for (int i = 0; i < 14; i++) begin
      cycle(1'b0, 1'b0, '0);
      if (last_valid) begin
        check("t4_head_pc", last_pc, 32'h400);
        check("t4_head_hw", {16'd0, last_hw}, {16'd0, mem_hw(32'h400)});
      end
    end
    check("t4_req_count", req_log.size(), 32'd2);
    check("t4_req1", req_log[1], 32'h404);
    check("t4_valid", {31'd0, last_valid}, 32'd1);
    repeat (20) cycle(1'b1, 1'b0, '0);
    for (int i = 0; i < 4; i++) begin
      check("t4_order", pop_pc_log[i], 32'h400 + 32'(2 * i));
    end

    // Branch coinciding with a response and a pop
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (pend.size() > 0 && pend[0].due == cyc) begin
        cycle(1'b1, 1'b1, 32'h0000_0500);
        found = 1'b1;
      end else begin
        cycle(1'b1, 1'b0, '0);
      end
    end
    check("t5_coincide_seen", {31'd0, found}, 32'd1);
    cycle(1'b1, 1'b0, '0);
    check("t5_empty", {31'd0, last_valid}, 32'd0);
    check("t5_no_req_yet", {31'd0, last_req}, 32'd0);
    cycle(1'b1, 1'b0, '0);
    check("t5_req", {31'd0, last_req}, 32'd1);
    check("t5_addr", last_addr, 32'h500);
    repeat (6) cycle(1'b1, 1'b0, '0);

    // Asynchronous reset while waiting on memory
    lat = 3;
    cycle(1'b1, 1'b1, 32'h0000_0600);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      cycle(1'b1, 1'b0, '0);
      found = last_req;
    end
    check("t6_req_seen", {31'd0, found}, 32'd1);
    rst = 1'b0;
    pend.delete();
    #1;
    check_reset_outputs("t6_async");
    repeat (2) @(negedge clk);
    #1;
    check_reset_outputs("t6_hold");
    @(negedge clk);
    rst    = 1'b1;
    exp_pc = RESET_PC;
    lat    = 1;
    clear_logs();
    repeat (8) cycle(1'b1, 1'b0, '0);
    check("t6_req0", req_log[0], RESET_PC);
    check("t6_pc0", pop_pc_log[0], RESET_PC);

    // Random traffic: stalls, branches, variable memory latency
    for (int i = 0; i < 400; i++) begin
      lat = $urandom_range(1, 4);
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 29) == 0, $urandom_range(0, 32'hFFFF));
    end
    check("pops_seen", {31'd0, pops > 60}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
